mem_port_master: RTL
====================

# mem_port_master

Initiator-side memory access controller for the multicycle MIPS core. It accepts word transactions from two clients, instruction fetch and data load/store, and arbitrates between them with fixed priority. It drives the unified `Memory` array through that array's `Address`/`writeData`/`writeEnable`/`MemData` interface. Each transaction runs through a three-state FSM: address registered, single-cycle access, one-cycle done pulse. The FSM also checks bounds and alignment before touching memory.

## Interface
- `DEPTH`, 1024: number of words in the attached memory; valid index range 0..DEPTH-1.
- `ADDR_SHIFT`, 0: client address is shifted right by this amount to form the memory index; 0 = word-indexed, 2 = byte-addressed.

Clock and reset:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high reset.

Data client:
- `dReq`  in  1  data request; held until `dDone`.
- `dWrite`  in  1  1 = store, 0 = load; sampled with `dReq`.
- `dAddr`  in  32  client address.
- `dWData`  in  32  store data.
- `dRData`  out  32  load result, registered.
- `dDone`  out  1  one-cycle completion pulse.
- `dErr`  out  1  valid with `dDone`.

Instruction-fetch client (read-only):
- `iReq`  in  1  fetch request; held until `iDone`.
- `iAddr`  in  32  fetch address.
- `iRData`  out  32  fetched word, registered.
- `iDone`  out  1  one-cycle completion pulse.
- `iErr`  out  1  valid with `iDone`.

Status and memory side:
- `busy`  out  1  high whenever state is not IDLE.
- `memAddress`  out  32  registered memory index; drives `Memory.Address`.
- `memWriteData`  out  32  registered store data; drives `Memory.writeData`.
- `memWriteEnable`  out  1  drives `Memory.writeEnable`.
- `memReadData`  in  32  from `Memory.MemData`; combinational read.

## Operation
- FSM states: IDLE, ACCESS, DONE.
  - IDLE -> ACCESS when `dReq | iReq`.
  - ACCESS -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- Arbitration happens only in IDLE, with fixed priority: data over fetch. A losing `iReq` simply stays pending; nothing is queued.
- On accept, the controller registers:
  - index = addr >> ADDR_SHIFT into `memAddress`;
  - `dWData` into `memWriteData` (data grant only);
  - the op type and owner.
- The error check is also registered on accept. `err` = (index >= DEPTH) or (ADDR_SHIFT > 0 and addr[ADDR_SHIFT-1:0] != 0).
- `memWriteEnable` = (state == ACCESS) & write & !err & !reset. It is gated combinationally, so reset in the ACCESS cycle suppresses the write.
- Loads and fetches: at the posedge ending ACCESS, `memReadData` is captured into the owner's RData register.
  - If err, that register is loaded with 0 instead and memory is not relied on.
  - The other client's RData register holds its value.
- Stores: `dRData` holds its previous value.
- DONE asserts the owner's Done for exactly one cycle, with Err = err.
- Clients must deassert Req in the Done cycle. If Req is still high in the following IDLE cycle, it is a new transaction.
- Reset, at any state:
  - next state IDLE; `dRData`, `iRData`, `memAddress` and `memWriteData` = 0;
  - all Done/Err = 0 and `busy` = 0;
  - any in-flight transaction is dropped with no Done.

## Timing
- Request seen in IDLE at cycle N, then:
  - N+1: ACCESS (write strobe here);
  - N+2: DONE (Done and RData valid);
  - N+3: IDLE, which can accept again.
- Latency is 2 cycles request-to-done; throughput is 1 transaction per 3 cycles.
- When both requests arrive at N: data completes at N+2 and fetch is accepted at N+3, completing at N+5.
- `busy` is high in N+1 and N+2.
- `memAddress` is stable from N+1 until the next accept.
- Error transactions keep the same 2-cycle latency and never raise `memWriteEnable`.

## Test plan
- Reset: hold `reset` 2 cycles with requests active -> all outputs 0, `busy`=0, no Done for 2 cycles after release unless a Req is present.
- Load: memory preloaded with word 5 at index 5; `dReq`=1, `dWrite`=0, `dAddr`=5 at N -> `dDone`=1, `dRData`=5, `dErr`=0 at N+2; `memWriteEnable` never high.
- Store then load: write 0xDEADBEEF to index 20 -> `memWriteEnable`=1 only at N+1 with `memAddress`=20. A subsequent load of 20 returns 0xDEADBEEF.
- Contention: `dReq` (load index 3) and `iReq` (index 128) at the same cycle -> `dDone` at N+2 with 3; `iDone` at N+5 with `iRData` = memory[128] (0x00221820 preloaded).
- Errors:
  - `dAddr`=1024 store -> `dErr`=1, `memWriteEnable` stays 0, memory unchanged.
  - With ADDR_SHIFT=2, `iAddr`=0x201 -> `iErr`=1 and `iRData`=0.
- Reset mid-write: assert `reset` during ACCESS of a store of 0x12345678 to index 7 -> no write (index 7 still reads 7), no `dDone`, FSM in IDLE next cycle.

Source files
------------

// File: rtl/mem_port_master.sv
// mem_port_master: initiator-side memory access controller.
// Arbitrates word transactions from a data client and an instruction-fetch
// client (data has fixed priority) onto a single-cycle-read memory port.
// Each transaction takes IDLE -> ACCESS -> DONE. Bounds and alignment are
// checked on accept, and a failing transaction never touches memory.
module mem_port_master #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        dReq,
    input  logic        dWrite,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWData,
    output logic [31:0] dRData,
    output logic        dDone,
    output logic        dErr,

    input  logic        iReq,
    input  logic [31:0] iAddr,
    output logic [31:0] iRData,
    output logic        iDone,
    output logic        iErr,

    output logic        busy,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWriteEnable,
    input  logic [31:0] memReadData
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    // Low address bits that must be zero when the client address is byte-based.
    localparam logic [31:0] ALIGN_MASK = (32'd1 << ADDR_SHIFT) - 32'd1;
    localparam logic [31:0] DEPTH_W    = 32'(DEPTH);

    state_t      state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        write_q, write_d;
    logic        owner_data_q, owner_data_d;   // 1 = data client owns the transaction
    logic        err_q, err_d;

    logic        accept;
    logic [31:0] req_addr;
    logic [31:0] req_index;
    logic        req_err;

    // Arbitration and request decode: data wins, the fetch request just waits.
    always_comb begin
        accept    = (state_q == ST_IDLE) && (dReq || iReq);
        req_addr  = dReq ? dAddr : iAddr;
        req_index = req_addr >> ADDR_SHIFT;
        req_err   = (req_index >= DEPTH_W) || ((req_addr & ALIGN_MASK) != 32'd0);
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (dReq || iReq) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture the request on accept, read data at end of ACCESS.
    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        d_rdata_d    = d_rdata_q;
        i_rdata_d    = i_rdata_q;
        write_d      = write_q;
        owner_data_d = owner_data_q;
        err_d        = err_q;

        if (accept) begin
            mem_addr_d   = req_index;
            write_d      = dReq && dWrite;
            owner_data_d = dReq;
            err_d        = req_err;
            if (dReq) mem_wdata_d = dWData;
        end

        if ((state_q == ST_ACCESS) && !write_q) begin
            if (owner_data_q) d_rdata_d = err_q ? 32'd0 : memReadData;
            else              i_rdata_d = err_q ? 32'd0 : memReadData;
        end
    end

    // Datapath registers; reset clears every visible register and drops the transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            d_rdata_q    <= 32'd0;
            i_rdata_q    <= 32'd0;
            write_q      <= 1'b0;
            owner_data_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            d_rdata_q    <= d_rdata_d;
            i_rdata_q    <= i_rdata_d;
            write_q      <= write_d;
            owner_data_q <= owner_data_d;
            err_q        <= err_d;
        end
    end

    // Outputs decoded from state; the write strobe is also gated by reset directly.
    always_comb begin
        busy           = (state_q != ST_IDLE);
        dDone          = (state_q == ST_DONE) && owner_data_q;
        iDone          = (state_q == ST_DONE) && !owner_data_q;
        dErr           = dDone && err_q;
        iErr           = iDone && err_q;
        memWriteEnable = (state_q == ST_ACCESS) && write_q && !err_q && !reset;
        memAddress     = mem_addr_q;
        memWriteData   = mem_wdata_q;
        dRData         = d_rdata_q;
        iRData         = i_rdata_q;
    end

endmodule
